// File: rtl/frog_pkg.sv
// -----------------------------------------------------------------------------
// frog_pkg
// Shared definitions for the frog player controller and its neighbours
// (car/log lane controllers use the same playfield defaults).
//   - facing_t    : sprite orientation / hop direction encoding
//   - hop_state_t : frog hop FSM states
//   - playfield and sprite ROM geometry defaults
//   - f_cnt_width : width of a counter that must hold 0 .. v-1
// -----------------------------------------------------------------------------
package frog_pkg;

    typedef enum logic [1:0] {
        FACE_UP = 2'b00,
        FACE_DN = 2'b01,
        FACE_LT = 2'b10,
        FACE_RT = 2'b11
    } facing_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_HOP      = 2'b01,
        ST_COOLDOWN = 2'b10
    } hop_state_t;

    // Playfield defaults shared with the lane controllers
    localparam int c_DEF_TILE_SIZE   = 32;
    localparam int c_DEF_GAME_WIDTH  = 640;
    localparam int c_DEF_GAME_HEIGHT = 480;

    // The frog bitmap is stored at a fixed 32x32 resolution
    localparam int c_ROM_DIM   = 32;
    localparam int c_ROM_IDX_W = 5;

    // Counter width for a count range of 0 .. v-1 (never narrower than 1 bit)
    function automatic int f_cnt_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/frog_sprite_rom.sv
// -----------------------------------------------------------------------------
// frog_sprite_rom
// Combinational 32x32 frog bitmap, drawn facing up. Indices are in tile
// coordinates; for tiles other than 32 px the index is rescaled onto the
// 32x32 bitmap (nearest neighbour).
// Ports:
//   i_Row_Idx  row within tile    (0 = top)
//   i_Col_Idx  column within tile (0 = left)
//   o_Pixel    1 = frog pixel
// -----------------------------------------------------------------------------
module frog_sprite_rom
    import frog_pkg::*;
#(
    parameter int c_TILE_SIZE = 32
) (
    input  logic [$clog2(c_TILE_SIZE)-1:0] i_Row_Idx,
    input  logic [$clog2(c_TILE_SIZE)-1:0] i_Col_Idx,
    output logic                           o_Pixel
);

    localparam int c_IDX_W = $clog2(c_TILE_SIZE);

    logic [c_ROM_IDX_W-1:0] w_Row;
    logic [c_ROM_IDX_W-1:0] w_Col;
    logic [c_ROM_DIM-1:0]   w_Bits;

    generate
        if (c_IDX_W >= c_ROM_IDX_W) begin : g_down
            assign w_Row = i_Row_Idx[c_IDX_W-1 -: c_ROM_IDX_W];
            assign w_Col = i_Col_Idx[c_IDX_W-1 -: c_ROM_IDX_W];
        end else begin : g_up
            assign w_Row = {i_Row_Idx, {(c_ROM_IDX_W-c_IDX_W){1'b0}}};
            assign w_Col = {i_Col_Idx, {(c_ROM_IDX_W-c_IDX_W){1'b0}}};
        end
    endgenerate

    // MSB of each row word is column 0
    always_comb begin
        w_Bits = '0;
        case (w_Row)
            5'd0:  w_Bits = 32'h00000000;
            5'd1:  w_Bits = 32'h03C003C0;
            5'd2:  w_Bits = 32'h07E007E0;
            5'd3:  w_Bits = 32'h0E700E70;
            5'd4:  w_Bits = 32'h0C3FFC30;
            5'd5:  w_Bits = 32'h0C7FFE30;
            5'd6:  w_Bits = 32'h07FFFFE0;
            5'd7:  w_Bits = 32'h03FFFFC0;
            5'd8:  w_Bits = 32'h01FFFF80;
            5'd9:  w_Bits = 32'h00FFFF00;
            5'd10: w_Bits = 32'h01FFFF80;
            5'd11: w_Bits = 32'h03F81FC0;
            5'd12: w_Bits = 32'h07F00FE0;
            5'd13: w_Bits = 32'h0FF00FF0;
            5'd14: w_Bits = 32'h1FFFFFF8;
            5'd15: w_Bits = 32'h3FFFFFFC;
            5'd16: w_Bits = 32'h3FFFFFFC;
            5'd17: w_Bits = 32'h1FFFFFF8;
            5'd18: w_Bits = 32'h0FFFFFF0;
            5'd19: w_Bits = 32'h07FFFFE0;
            5'd20: w_Bits = 32'h03FFFFC0;
            5'd21: w_Bits = 32'h07FFFFE0;
            5'd22: w_Bits = 32'h0FF00FF0;
            5'd23: w_Bits = 32'h1FE007F8;
            5'd24: w_Bits = 32'h3FC003FC;
            5'd25: w_Bits = 32'h7F8001FE;
            5'd26: w_Bits = 32'h7E00007E;
            5'd27: w_Bits = 32'hFC00003F;
            5'd28: w_Bits = 32'hF800001F;
            5'd29: w_Bits = 32'hE0000007;
            5'd30: w_Bits = 32'hC0000003;
            default: w_Bits = 32'h00000000;
        endcase
    end

    assign o_Pixel = w_Bits[5'd31 - w_Col];

endmodule

// File: rtl/frog_hop_ctrl.sv
// -----------------------------------------------------------------------------
// frog_hop_ctrl
// Grid-stepped frog sprite controller. A one-hot button press hops the frog
// one tile, animated in c_HOP_STEPS sub-steps; holding the button auto-repeats
// after a cooldown. Hops that would leave the playfield are rejected with a
// single o_Blocked pulse per press. i_Respawn returns the frog to its start.
// Ports:
//   i_Clk, i_Rst                 clock, synchronous active-high reset
//   i_Col_Count_Div/Row          current pixel column / row
//   i_Up/i_Dn/i_Lt/i_Rt          debounced direction buttons
//   i_Respawn                    pulse: return frog to start
//   o_Frog_X/o_Frog_Y            sprite top-left corner
//   o_Facing                     00 up, 01 down, 10 left, 11 right
//   o_Busy                       hop or cooldown in progress
//   o_Hop_Done                   pulse when the final sub-step lands
//   o_Blocked                    pulse when a hop is rejected at the edge
//   o_Draw_Frog                  sprite pixel on (1 cycle latency)
// -----------------------------------------------------------------------------
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int c_TILE_SIZE       = c_DEF_TILE_SIZE,
    parameter int c_GAME_WIDTH      = c_DEF_GAME_WIDTH,
    parameter int c_GAME_HEIGHT     = c_DEF_GAME_HEIGHT,
    parameter int c_START_X         = 304,
    parameter int c_START_Y         = 448,
    parameter int c_HOP_STEPS       = 4,
    parameter int c_STEP_CYCLES     = 637500,
    parameter int c_COOLDOWN_CYCLES = 2550000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [9:0] i_Col_Count_Div,
    input  logic [9:0] i_Row_Count_Div,
    input  logic       i_Up,
    input  logic       i_Dn,
    input  logic       i_Lt,
    input  logic       i_Rt,
    input  logic       i_Respawn,
    output logic [9:0] o_Frog_X,
    output logic [9:0] o_Frog_Y,
    output logic [1:0] o_Facing,
    output logic       o_Busy,
    output logic       o_Hop_Done,
    output logic       o_Blocked,
    output logic       o_Draw_Frog
);

    localparam int c_IDX_W  = $clog2(c_TILE_SIZE);
    localparam int c_STEP_W = f_cnt_width(c_STEP_CYCLES);
    localparam int c_COOL_W = f_cnt_width(c_COOLDOWN_CYCLES);
    localparam int c_SUB_W  = f_cnt_width(c_HOP_STEPS);

    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(c_STEP_CYCLES - 1);
    localparam logic [c_COOL_W-1:0] c_COOL_LAST = c_COOL_W'(c_COOLDOWN_CYCLES - 1);
    localparam logic [c_SUB_W-1:0]  c_SUB_LAST  = c_SUB_W'(c_HOP_STEPS - 1);

    localparam logic [10:0] c_TILE_11 = 11'(c_TILE_SIZE);
    localparam logic [10:0] c_X_MAX   = 11'(c_GAME_WIDTH - c_TILE_SIZE);
    localparam logic [10:0] c_Y_MAX   = 11'(c_GAME_HEIGHT - c_TILE_SIZE);
    localparam logic [9:0]  c_SUB_PX  = 10'(c_TILE_SIZE / c_HOP_STEPS);
    localparam logic [9:0]  c_X0      = 10'(c_START_X);
    localparam logic [9:0]  c_Y0      = 10'(c_START_Y);

    hop_state_t          r_State;
    facing_t             r_Facing;
    facing_t             r_Dir;
    facing_t             r_Blk_Dir;
    logic                r_Blk_Hold;
    logic [9:0]          r_X;
    logic [9:0]          r_Y;
    logic [c_STEP_W-1:0] r_Step_Cnt;
    logic [c_SUB_W-1:0]  r_Sub_Cnt;
    logic [c_COOL_W-1:0] r_Cool_Cnt;
    logic                r_Hop_Done;
    logic                r_Blocked;
    logic                r_Draw;

    // ---------------- request decode ----------------
    logic [3:0] w_Btn;
    logic       w_Req_Valid;
    facing_t    w_Req_Dir;
    logic       w_Held;
    logic       w_Accept;

    assign w_Btn       = {i_Rt, i_Lt, i_Dn, i_Up};
    assign w_Req_Valid = $onehot(w_Btn);

    always_comb begin
        w_Req_Dir = FACE_UP;
        case (w_Btn)
            4'b0010: w_Req_Dir = FACE_DN;
            4'b0100: w_Req_Dir = FACE_LT;
            4'b1000: w_Req_Dir = FACE_RT;
            default: w_Req_Dir = FACE_UP;
        endcase
    end

    // A rejected press stays suppressed until released or redirected
    assign w_Held   = r_Blk_Hold && w_Req_Valid && (w_Req_Dir == r_Blk_Dir);
    assign w_Accept = w_Req_Valid && !w_Held;

    // ---------------- target bounds (11-bit so 0-T goes large, not wrap) ----
    logic [10:0] w_Tgt_X;
    logic [10:0] w_Tgt_Y;
    logic        w_Tgt_Ok;

    always_comb begin
        w_Tgt_X = {1'b0, r_X};
        w_Tgt_Y = {1'b0, r_Y};
        case (w_Req_Dir)
            FACE_UP: w_Tgt_Y = {1'b0, r_Y} - c_TILE_11;
            FACE_DN: w_Tgt_Y = {1'b0, r_Y} + c_TILE_11;
            FACE_LT: w_Tgt_X = {1'b0, r_X} - c_TILE_11;
            default: w_Tgt_X = {1'b0, r_X} + c_TILE_11;
        endcase
    end

    assign w_Tgt_Ok = (w_Tgt_X <= c_X_MAX) && (w_Tgt_Y <= c_Y_MAX);

    // ---------------- sub-step move ----------------
    logic [9:0] w_Step_X;
    logic [9:0] w_Step_Y;

    always_comb begin
        w_Step_X = r_X;
        w_Step_Y = r_Y;
        case (r_Dir)
            FACE_UP: w_Step_Y = r_Y - c_SUB_PX;
            FACE_DN: w_Step_Y = r_Y + c_SUB_PX;
            FACE_LT: w_Step_X = r_X - c_SUB_PX;
            default: w_Step_X = r_X + c_SUB_PX;
        endcase
    end

    // ---------------- hop FSM ----------------
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Respawn) begin
            r_State    <= ST_IDLE;
            r_Facing   <= FACE_UP;
            r_Dir      <= FACE_UP;
            r_Blk_Dir  <= FACE_UP;
            r_Blk_Hold <= 1'b0;
            r_X        <= c_X0;
            r_Y        <= c_Y0;
            r_Step_Cnt <= '0;
            r_Sub_Cnt  <= '0;
            r_Cool_Cnt <= '0;
            r_Hop_Done <= 1'b0;
            r_Blocked  <= 1'b0;
        end else begin
            r_Hop_Done <= 1'b0;
            r_Blocked  <= 1'b0;
            r_Blk_Hold <= w_Held;
            case (r_State)
                ST_IDLE, ST_COOLDOWN: begin
                    if (r_State == ST_COOLDOWN && r_Cool_Cnt != c_COOL_LAST) begin
                        r_Cool_Cnt <= r_Cool_Cnt + 1'b1;
                    end else begin
                        // IDLE, or the last cooldown cycle (auto-repeat point)
                        r_Cool_Cnt <= '0;
                        r_State    <= ST_IDLE;
                        if (w_Accept) begin
                            r_Facing <= w_Req_Dir;
                            if (w_Tgt_Ok) begin
                                r_Dir      <= w_Req_Dir;
                                r_State    <= ST_HOP;
                                r_Step_Cnt <= '0;
                                r_Sub_Cnt  <= '0;
                            end else begin
                                r_Blocked  <= 1'b1;
                                r_Blk_Hold <= 1'b1;
                                r_Blk_Dir  <= w_Req_Dir;
                            end
                        end
                    end
                end
                ST_HOP: begin
                    if (r_Step_Cnt == c_STEP_LAST) begin
                        r_Step_Cnt <= '0;
                        r_X        <= w_Step_X;
                        r_Y        <= w_Step_Y;
                        if (r_Sub_Cnt == c_SUB_LAST) begin
                            r_Sub_Cnt  <= '0;
                            r_Cool_Cnt <= '0;
                            r_Hop_Done <= 1'b1;
                            r_State    <= ST_COOLDOWN;
                        end else begin
                            r_Sub_Cnt <= r_Sub_Cnt + 1'b1;
                        end
                    end else begin
                        r_Step_Cnt <= r_Step_Cnt + 1'b1;
                    end
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    // ---------------- draw path ----------------
    logic [10:0]        w_X_End;
    logic [10:0]        w_Y_End;
    logic               w_Hit;
    logic [c_IDX_W-1:0] w_Rel_R;
    logic [c_IDX_W-1:0] w_Rel_C;
    logic [c_IDX_W-1:0] w_Rom_R;
    logic [c_IDX_W-1:0] w_Rom_C;
    logic               w_Rom_Pix;

    assign w_X_End = {1'b0, r_X} + c_TILE_11;
    assign w_Y_End = {1'b0, r_Y} + c_TILE_11;
    assign w_Hit   = (i_Col_Count_Div >= r_X) && ({1'b0, i_Col_Count_Div} < w_X_End) &&
                     (i_Row_Count_Div >= r_Y) && ({1'b0, i_Row_Count_Div} < w_Y_End);
    assign w_Rel_R = c_IDX_W'(i_Row_Count_Div - r_Y);
    assign w_Rel_C = c_IDX_W'(i_Col_Count_Div - r_X);

    // Tile is a power of two, so T-1-k is just ~k
    always_comb begin
        w_Rom_R = w_Rel_R;
        w_Rom_C = w_Rel_C;
        case (r_Facing)
            FACE_UP: begin w_Rom_R = w_Rel_R;  w_Rom_C = w_Rel_C; end
            FACE_DN: begin w_Rom_R = ~w_Rel_R; w_Rom_C = w_Rel_C; end
            FACE_LT: begin w_Rom_R = w_Rel_C;  w_Rom_C = w_Rel_R; end
            default: begin w_Rom_R = ~w_Rel_C; w_Rom_C = w_Rel_R; end
        endcase
    end

    frog_sprite_rom #(
        .c_TILE_SIZE(c_TILE_SIZE)
    ) u_rom (
        .i_Row_Idx(w_Rom_R),
        .i_Col_Idx(w_Rom_C),
        .o_Pixel  (w_Rom_Pix)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_Draw <= 1'b0;
        else       r_Draw <= w_Hit && w_Rom_Pix;
    end

    assign o_Frog_X    = r_X;
    assign o_Frog_Y    = r_Y;
    assign o_Facing    = r_Facing;
    assign o_Busy      = (r_State != ST_IDLE);
    assign o_Hop_Done  = r_Hop_Done;
    assign o_Blocked   = r_Blocked;
    assign o_Draw_Frog = r_Draw;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
module tb_frog_hop_ctrl;

    localparam int T  = 32;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int SX = 304;
    localparam int SY = 448;
    localparam int HS = 4;
    localparam int SC = 2;
    localparam int CC = 4;
    localparam int D  = SC * HS;

    logic       clk = 1'b0;
    logic       rst, up, dn, lt, rt, resp;
    logic [9:0] col, row;
    logic [9:0] fx, fy;
    logic [1:0] face;
    logic       busy, done, blk, draw;

    always #5 clk = ~clk;

    frog_hop_ctrl #(
        .c_TILE_SIZE(T), .c_GAME_WIDTH(W), .c_GAME_HEIGHT(H),
        .c_START_X(SX), .c_START_Y(SY), .c_HOP_STEPS(HS),
        .c_STEP_CYCLES(SC), .c_COOLDOWN_CYCLES(CC)
    ) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Col_Count_Div(col), .i_Row_Count_Div(row),
        .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt), .i_Respawn(resp),
        .o_Frog_X(fx), .o_Frog_Y(fy), .o_Facing(face), .o_Busy(busy),
        .o_Hop_Done(done), .o_Blocked(blk), .o_Draw_Frog(draw)
    );

    int tests = 0;
    int fails = 0;
    int n = 0;

    // Reference model: a hop is described by its start edge and start point;
    // position at any edge follows from elapsed time.
    int   hop_e  = -1;
    int   bx     = SX;
    int   by     = SY;
    int   ddx    = 0;
    int   ddy    = 0;
    int   mface  = 0;
    bit   hold_v = 0;
    int   hold_d = 0;
    logic [31:0] bmp [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int substeps(input int nn);
        int k;
        if (hop_e < 0 || nn < hop_e) return 0;
        k = (nn - hop_e) / SC;
        return (k > HS) ? HS : k;
    endfunction

    function automatic int mpos_x(input int nn);
        return bx + ddx * substeps(nn) * (T / HS);
    endfunction

    function automatic int mpos_y(input int nn);
        return by + ddy * substeps(nn) * (T / HS);
    endfunction

    function automatic int draw_model(input int c, input int r, input int x, input int y, input int f);
        int rr, cc, ri, ci;
        logic [31:0] wd;
        if (c < x || c >= x + T || r < y || r >= y + T) return 0;
        rr = r - y;
        cc = c - x;
        case (f)
            0:       begin ri = rr;         ci = cc; end
            1:       begin ri = T - 1 - rr; ci = cc; end
            2:       begin ri = cc;         ci = rr; end
            default: begin ri = T - 1 - cc; ci = rr; end
        endcase
        wd = bmp[ri];
        return int'(wd[31 - ci]);
    endfunction

    // Apply one clock edge with the current inputs, advance the model, compare.
    task automatic tick();
        int  cx, cy, ed, dir, tx, ty, eblk, cnt;
        bit  valid, held, free;
        n++;
        eblk = 0;
        cx = mpos_x(n - 1);
        cy = mpos_y(n - 1);
        ed = rst ? 0 : draw_model(int'(col), int'(row), cx, cy, mface);
        if (rst || resp) begin
            hop_e = -1; bx = SX; by = SY; mface = 0; hold_v = 0;
        end else begin
            cnt   = int'(up) + int'(dn) + int'(lt) + int'(rt);
            valid = (cnt == 1);
            dir   = up ? 0 : dn ? 1 : lt ? 2 : 3;
            held  = hold_v && valid && (dir == hold_d);
            hold_v = held;
            free  = (hop_e < 0) || (n >= hop_e + D + CC);
            if (free) begin
                if (hop_e >= 0) begin bx = cx; by = cy; hop_e = -1; end
                if (valid && !held) begin
                    tx = cx; ty = cy;
                    case (dir)
                        0: ty -= T;
                        1: ty += T;
                        2: tx -= T;
                        default: tx += T;
                    endcase
                    mface = dir;
                    if (tx >= 0 && tx <= W - T && ty >= 0 && ty <= H - T) begin
                        hop_e = n; bx = cx; by = cy;
                        ddx = (tx - cx) / T; ddy = (ty - cy) / T;
                    end else begin
                        eblk = 1; hold_v = 1; hold_d = dir;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("m_x", fx, mpos_x(n));
        chk("m_y", fy, mpos_y(n));
        chk("m_face", face, mface);
        chk("m_busy", busy, (hop_e >= 0 && n < hop_e + D + CC) ? 1 : 0);
        chk("m_done", done, (hop_e >= 0 && n == hop_e + D) ? 1 : 0);
        chk("m_blk", blk, eblk);
        chk("m_draw", draw, ed);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy; i++) tick();
        chk(tag, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt, bcnt, sel, len, v;
        logic [31:0] wd;
        bmp[0]  = 32'h00000000; bmp[1]  = 32'h03C003C0; bmp[2]  = 32'h07E007E0; bmp[3]  = 32'h0E700E70;
        bmp[4]  = 32'h0C3FFC30; bmp[5]  = 32'h0C7FFE30; bmp[6]  = 32'h07FFFFE0; bmp[7]  = 32'h03FFFFC0;
        bmp[8]  = 32'h01FFFF80; bmp[9]  = 32'h00FFFF00; bmp[10] = 32'h01FFFF80; bmp[11] = 32'h03F81FC0;
        bmp[12] = 32'h07F00FE0; bmp[13] = 32'h0FF00FF0; bmp[14] = 32'h1FFFFFF8; bmp[15] = 32'h3FFFFFFC;
        bmp[16] = 32'h3FFFFFFC; bmp[17] = 32'h1FFFFFF8; bmp[18] = 32'h0FFFFFF0; bmp[19] = 32'h07FFFFE0;
        bmp[20] = 32'h03FFFFC0; bmp[21] = 32'h07FFFFE0; bmp[22] = 32'h0FF00FF0; bmp[23] = 32'h1FE007F8;
        bmp[24] = 32'h3FC003FC; bmp[25] = 32'h7F8001FE; bmp[26] = 32'h7E00007E; bmp[27] = 32'hFC00003F;
        bmp[28] = 32'hF800001F; bmp[29] = 32'hE0000007; bmp[30] = 32'hC0000003; bmp[31] = 32'h00000000;

        rst = 1; up = 0; dn = 0; lt = 0; rt = 0; resp = 0; col = 0; row = 0;
        tick(); tick();
        chk("rst_x", fx, 304);
        chk("rst_y", fy, 448);
        chk("rst_face", face, 0);
        chk("rst_busy", busy, 0);
        chk("rst_draw", draw, 0);
        rst = 0;
        tick();

        // Hop up, then auto-repeat a second hop while held
        up = 1; dcnt = 0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            dcnt += int'(done);
            if (k == 2) chk("hop1_y440", fy, 440);
            if (k == 8) begin chk("hop1_y416", fy, 416); chk("hop1_done", done, 1); end
            if (k == 12) chk("repeat_busy", busy, 1);
            if (k == 20) begin chk("hop2_y384", fy, 384); chk("two_done", dcnt, 2); end
        end
        up = 0;
        wait_idle("idle_after_repeat");

        // Blocked at bottom edge, one pulse per press; two buttons = no request
        resp = 1; tick(); resp = 0;
        chk("respawn_y", fy, 448);
        dn = 1; tick();
        chk("dn_blk", blk, 1);
        chk("dn_face", face, 1);
        chk("dn_y", fy, 448);
        chk("dn_busy", busy, 0);
        bcnt = 0;
        for (int k = 0; k < 4; k++) begin tick(); bcnt += int'(blk); end
        chk("dn_blk_once", bcnt, 0);
        dn = 0; up = 1; lt = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("multi_busy", busy, 0);
        chk("multi_x", fx, 304);
        chk("multi_y", fy, 448);
        up = 0; lt = 0; tick();

        // Walk to the left edge; the last request is rejected without wrapping
        lt = 1;
        for (int k = 0; k < 200 && !blk; k++) tick();
        chk("left_blk", blk, 1);
        chk("left_x", fx, 16);
        chk("left_busy", busy, 0);
        lt = 0; tick();

        // Reset mid-hop
        up = 1; tick(); up = 0; tick(); tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_mid_x", fx, 304);
        chk("rst_mid_y", fy, 448);
        chk("rst_mid_busy", busy, 0);
        tick();

        // Respawn during the second sub-step
        up = 1; tick(); up = 0;
        tick(); tick();
        chk("resp_pre_y", fy, 440);
        tick();
        resp = 1; tick(); resp = 0;
        chk("resp_x", fx, 304);
        chk("resp_y", fy, 448);
        chk("resp_busy", busy, 0);
        chk("resp_done", done, 0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin tick(); dcnt += int'(done); end
        chk("resp_no_done", dcnt, 0);

        // Respawn coincident with landing
        up = 1; tick(); up = 0;
        for (int k = 0; k < D - 1; k++) tick();
        resp = 1; tick(); resp = 0;
        chk("land_resp_done", done, 0);
        chk("land_resp_y", fy, 448);

        // Left-facing draw
        lt = 1; tick(); lt = 0;
        wait_idle("idle_before_draw");
        chk("draw_face", face, 2);
        chk("draw_x", fx, 272);
        col = fx + 10'd3; row = fy + 10'd5; tick();
        wd = bmp[3];
        chk("draw_lt_3_5", draw, wd[31 - 5]);
        chk("draw_lt_3_5_on", draw, 1);
        col = fx + 10'd32; row = fy; tick();
        chk("draw_outside", draw, 0);

        // Randomized traffic against the model
        for (int s = 0; s < 70; s++) begin
            sel = $urandom_range(0, 19);
            len = $urandom_range(1, 25);
            up = 0; dn = 0; lt = 0; rt = 0;
            if (sel < 13) begin
                v = $urandom_range(0, 3);
                up = (v == 0); dn = (v == 1); lt = (v == 2); rt = (v == 3);
            end else if (sel < 16) begin
                v = $urandom_range(0, 15);
                up = v[0]; dn = v[1]; lt = v[2]; rt = v[3];
            end else if (sel == 19) begin
                resp = 1;
            end
            for (int k = 0; k < len; k++) begin
                col = 10'(int'(fx) + $urandom_range(0, 40) - 4);
                row = 10'(int'(fy) + $urandom_range(0, 40) - 4);
                tick();
                resp = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
